// File: rtl/align_pipe_pkg.sv
// Shared definitions for the FP add-path operand aligner: default operand
// format, significand layout and the unpacked operand record.
package align_pipe_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int GRS_W     = 3;
  localparam int SIG_W     = FP_FRAC_W + 1 + GRS_W;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } unpacked_op_t;

  // A zero exponent field encodes a subnormal, whose exponent is 1.
  function automatic logic [FP_EXP_W-1:0] eff_exp(input logic [FP_EXP_W-1:0] e);
    return (e == '0) ? FP_EXP_W'(1) : e;
  endfunction

endpackage

// File: rtl/align_pipe_sticky_shift.sv
// Right shift that folds every shifted-out bit into the LSB (sticky) and
// collapses to a lone sticky bit once the shift clears the whole word.
module sticky_shift #(
  parameter int W    = 27,
  parameter int SH_W = 8
) (
  input  logic [W-1:0]    din,
  input  logic [SH_W-1:0] shift,
  output logic [W-1:0]    dout
);

  localparam int CMP_W = (SH_W > 32) ? SH_W : 32;

  logic [CMP_W-1:0] shift_ext;
  logic [W-1:0]     lost_mask;

  assign shift_ext = CMP_W'(shift);

  always_comb begin
    lost_mask = '0;
    dout      = '0;
    if (shift_ext >= CMP_W'(W)) begin
      dout = {{(W-1){1'b0}}, |din};
    end else begin
      lost_mask = ~({W{1'b1}} << shift);
      dout      = din >> shift;
      dout[0]   = dout[0] | (|(din & lost_mask));
    end
  end

endmodule

// File: rtl/align_pipe.sv
// Two-stage significand aligner: stage 1 orders the operands by exponent,
// stage 2 right-shifts the smaller significand with guard/round/sticky.
module align_pipe
  import align_pipe_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int FRAC_W = FP_FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    a_sign,
  input  logic                    b_sign,
  input  logic [EXP_W-1:0]        a_exp,
  input  logic [EXP_W-1:0]        b_exp,
  input  logic [FRAC_W-1:0]       a_frac,
  input  logic [FRAC_W-1:0]       b_frac,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    big_sign,
  output logic                    small_sign,
  output logic [EXP_W-1:0]        big_exp,
  output logic [FRAC_W+GRS_W:0]   big_sig,
  output logic [FRAC_W+GRS_W:0]   small_sig,
  output logic                    swapped,
  output logic                    eff_sub
);

  localparam int SIG_LEN = FRAC_W + 1 + GRS_W;

  logic s1_valid, s2_valid, s1_adv, s2_adv;

  logic              a_hid, b_hid, swap;
  logic [EXP_W-1:0]  a_eexp, b_eexp;

  logic              s1_big_sign, s1_small_sign, s1_swap;
  logic              s1_big_hid, s1_small_hid;
  logic [EXP_W-1:0]  s1_big_exp, s1_shift;
  logic [FRAC_W-1:0] s1_big_frac, s1_small_frac;

  logic [SIG_LEN-1:0] big_ext, small_ext, small_aligned;

  // A stage may take new data when it is empty or its contents leave this edge.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  assign a_hid  = |a_exp;
  assign b_hid  = |b_exp;
  assign a_eexp = a_hid ? a_exp : EXP_W'(1);
  assign b_eexp = b_hid ? b_exp : EXP_W'(1);
  assign swap   = b_eexp > a_eexp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_big_sign   <= 1'b0;
      s1_small_sign <= 1'b0;
      s1_swap       <= 1'b0;
      s1_big_hid    <= 1'b0;
      s1_small_hid  <= 1'b0;
      s1_big_exp    <= '0;
      s1_shift      <= '0;
      s1_big_frac   <= '0;
      s1_small_frac <= '0;
    end else if (s1_adv && in_valid) begin
      s1_swap       <= swap;
      s1_big_sign   <= swap ? b_sign : a_sign;
      s1_small_sign <= swap ? a_sign : b_sign;
      s1_big_hid    <= swap ? b_hid  : a_hid;
      s1_small_hid  <= swap ? a_hid  : b_hid;
      s1_big_exp    <= swap ? b_eexp : a_eexp;
      s1_big_frac   <= swap ? b_frac : a_frac;
      s1_small_frac <= swap ? a_frac : b_frac;
      s1_shift      <= swap ? (b_eexp - a_eexp) : (a_eexp - b_eexp);
    end
  end

  assign big_ext   = {s1_big_hid,   s1_big_frac,   GRS_W'(0)};
  assign small_ext = {s1_small_hid, s1_small_frac, GRS_W'(0)};

  sticky_shift #(
    .W    (SIG_LEN),
    .SH_W (EXP_W)
  ) u_sticky_shift (
    .din   (small_ext),
    .shift (s1_shift),
    .dout  (small_aligned)
  );

  // Output registers only move when stage 2 advances, so a stall holds them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      big_sign   <= 1'b0;
      small_sign <= 1'b0;
      big_exp    <= '0;
      big_sig    <= '0;
      small_sig  <= '0;
      swapped    <= 1'b0;
      eff_sub    <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      big_sign   <= s1_big_sign;
      small_sign <= s1_small_sign;
      big_exp    <= s1_big_exp;
      big_sig    <= big_ext;
      small_sig  <= small_aligned;
      swapped    <= s1_swap;
      eff_sub    <= s1_big_sign ^ s1_small_sign;
    end
  end

endmodule

// File: doc/align_pipe.md
# align_pipe

Parametrised, pipelined successor to the combinational significand aligner in the FP add path. The block takes two unpacked operands, compares exponents, swaps them so the larger-exponent operand leads, and right-shifts the smaller significand (hidden bit included) with correct guard/round/sticky generation and saturation. It sits between operand unpack and the significand adder, and carries a valid/ready handshake so the add path can stall.

## Interface
- EXP_W, 8, exponent width
- FRAC_W, 23, stored fraction width; aligned significands are FRAC_W+4 bits: {hidden, frac, G, R, S}
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts pair this cycle
- a_sign, b_sign  in  1  operand signs
- a_exp, b_exp  in  EXP_W  biased exponents
- a_frac, b_frac  in  FRAC_W  stored fractions
- out_valid  out  1  aligned result present
- out_ready  in  1  downstream accepts result
- big_sign, small_sign  out  1  signs after swap
- big_exp  out  EXP_W  effective exponent of larger operand
- big_sig, small_sig  out  FRAC_W+4  aligned significands
- swapped  out  1  b was the larger operand
- eff_sub  out  1  big_sign XOR small_sign

## Operation
- Effective exponent: exp==0 gives exponent 1 and hidden bit 0 (subnormal); otherwise hidden bit 1.
- Stage 1: compare effective exponents; b larger (strictly) → swap=1; on a tie, no swap. Register big/small fields and shift = exp_big − exp_small (EXP_W bits, unsigned).
- Stage 2: ext = {hidden, frac, 3'b000}. big_sig = ext_big. small_sig = (ext_small >> shift) with bit 0 OR'd with OR of all shifted-out bits.
- Saturation: shift ≥ FRAC_W+4 → small_sig = 1 if ext_small ≠ 0, else 0.
- Zero operand (exp=0, frac=0) handled by the same rules; no special casing.
- No NaN/Inf handling; exp all-ones is passed through as an ordinary value.

## Timing
- Latency 2 cycles from accepted input to out_valid; throughput 1 pair/cycle when out_ready=1.
- s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational from out_ready, no registered skid).
- Transfer occurs on the rising clk edge with valid&ready high on the same side.
- While out_valid=1 and out_ready=0, all outputs hold stable; stage 1 fills, then in_ready=0.
- Simultaneous accept at input and output with both stages full: everything shifts one stage, no loss, no bubble.
- Reset (asynchronous, any cycle, including mid-stall): s1_valid=s2_valid=0, out_valid=0, all data outputs 0, swapped=0, eff_sub=0; in_ready=1 in the first cycle after release.
- Data registers update only on stage advance; valid registers are the only state that must reset for correctness, but all outputs reset to 0.

## Structure
- addpkg gains: localparam SIG_W = FRAC_W+4, GRS_W = 3; typedef struct unpacked_op_t {sign, exp, frac} parametrised by EXP_W/FRAC_W; function eff_exp().
- One sub-module: sticky_shift (combinational, parameter W and shift width): right shift with sticky OR and saturation. Instantiated in stage 2.
- Top holds the two pipeline stages and handshake logic.

## Test plan
- a=1.0 (exp 127, frac 0), b=1.0, out_ready=1 → after 2 cycles big_sig=small_sig=0x4000000, swapped=0, big_exp=127.
- a exp 125 frac 0, b exp 127 frac 0 → swapped=1, big_exp=127, small_sig=0x1000000.
- a exp 127 frac 0, b exp 122 frac 0x000001 → small_sig=0x0200001 (sticky set), eff_sub follows signs (a=0, b=1 → 1).
- a exp 254, b exp 54 frac 0x400000 → shift 200 saturates, small_sig=0x0000001; b=+0 same exps → small_sig=0.
- Back-to-back 4 pairs, out_ready low cycles 3–5 → in_ready low after stage 1 fills, outputs stable while stalled, all 4 results emerge in order with none lost or duplicated.
- rst_n asserted with both stages valid and stalled → out_valid=0 and outputs 0 immediately; first post-reset pair appears 2 cycles after acceptance.
